// File: rtl/rfid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rfid_pkg
// Description : Shared command codes, tag/reply enums and slot helper for the
//               Gen2-style RFID tag inventory/access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rfid_pkg;

  // Decoded command codes from the forward-link parser (6 is unused)
  localparam logic [2:0] CMD_QUERY    = 3'd0;
  localparam logic [2:0] CMD_QUERYREP = 3'd1;
  localparam logic [2:0] CMD_QUERYADJ = 3'd2;
  localparam logic [2:0] CMD_ACK      = 3'd3;
  localparam logic [2:0] CMD_NAK      = 3'd4;
  localparam logic [2:0] CMD_REQRN    = 3'd5;
  localparam logic [2:0] CMD_OTHER    = 3'd7;

  // QUERYADJ up/down field encodings; any other value leaves Q unchanged
  localparam logic [2:0] UPDN_INC  = 3'b110;
  localparam logic [2:0] UPDN_DEC  = 3'b011;
  localparam logic [2:0] UPDN_SAME = 3'b000;

  typedef enum logic [2:0] {
    ST_READY     = 3'd0,
    ST_ARBITRATE = 3'd1,
    ST_REPLY     = 3'd2,
    ST_ACKED     = 3'd3,
    ST_OPEN      = 3'd4
  } tag_state_e;

  typedef enum logic [1:0] {
    RPL_RN16   = 2'd0,
    RPL_EPC    = 2'd1,
    RPL_HANDLE = 2'd2
  } rpl_type_e;

  // Slot counter load: low Q bits of r[14:0]; Q=0 gives slot 0, Q=15 keeps all 15 bits
  function automatic logic [14:0] slot_mask(input logic [15:0] r, input logic [3:0] q);
    logic [14:0] mask;
    mask = (15'h1 << q) - 15'h1;
    return r[14:0] & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rfid_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : rfid_lfsr16
// Description : Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), the
//               random source for RN16, slot and handle generation.
// Revision    : 1.0 - initial release
// ============================================================================
module rfid_lfsr16 #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  // Right-shifting form: taps 16,14,13,11 map onto bits 0,2,3,5
  always_comb begin
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d = {fb, lfsr_q[15:1]};
  end

  // Shift register, seeded on reset, advancing every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/rfid_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rfid_tag_ctrl
// Description : Tag inventory/access controller. Sequences the tag state on
//               parsed commands, manages Q/slot, RN16, handle and the
//               inventoried flag, and requests replies from the encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module rfid_tag_ctrl
  import rfid_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [15:0] EPC_WORD  = 16'h3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_code,
  input  logic        cmd_crc_ok,
  input  logic [3:0]  cmd_q,
  input  logic        cmd_target,
  input  logic [2:0]  cmd_updn,
  input  logic [15:0] cmd_rn,
  output logic        rpl_valid,
  input  logic        rpl_ready,
  output logic [1:0]  rpl_type,
  output logic [15:0] rpl_data,
  output logic [2:0]  tag_state,
  output logic        inv_flag
);

  tag_state_e  state_q, state_d;
  rpl_type_e   rpl_type_q, rpl_type_d;
  logic        inv_flag_q, inv_flag_d;
  logic        rpl_valid_q, rpl_valid_d;
  logic [15:0] rpl_data_q, rpl_data_d;
  logic [3:0]  q_q, q_d;
  logic [14:0] slot_q, slot_d;
  logic [15:0] rn16_q, rn16_d;
  logic [15:0] handle_q, handle_d;

  logic [15:0] r;
  logic        cmd_accept;
  logic        is_acc;
  logic        reload;
  logic [3:0]  reload_q;
  logic [3:0]  q_adj;
  logic [14:0] slot_dec;
  logic [14:0] slot_new;
  logic        inv_new;

  rfid_lfsr16 #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (r)
  );

  // Command decode and state sequencing; a held reply blocks new commands
  always_comb begin
    state_d     = state_q;
    inv_flag_d  = inv_flag_q;
    rpl_valid_d = rpl_valid_q;
    rpl_type_d  = rpl_type_q;
    rpl_data_d  = rpl_data_q;
    q_d         = q_q;
    slot_d      = slot_q;
    rn16_d      = rn16_q;
    handle_d    = handle_q;
    reload      = 1'b0;
    reload_q    = q_q;
    slot_new    = 15'd0;
    slot_dec    = slot_q - 15'd1;
    is_acc      = (state_q == ST_ACKED) || (state_q == ST_OPEN);
    inv_new     = inv_flag_q ^ is_acc;
    cmd_accept  = cmd_valid & ~rpl_valid_q;

    q_adj = q_q;
    if (cmd_updn == UPDN_INC && q_q != 4'd15)      q_adj = q_q + 4'd1;
    else if (cmd_updn == UPDN_DEC && q_q != 4'd0)  q_adj = q_q - 4'd1;

    if (rpl_valid_q && rpl_ready) rpl_valid_d = 1'b0;

    if (cmd_accept && cmd_crc_ok) begin
      case (cmd_code)
        CMD_QUERY: begin
          q_d        = cmd_q;
          inv_flag_d = inv_new;
          if (cmd_target != inv_new) begin
            state_d = ST_READY;
          end else begin
            reload   = 1'b1;
            reload_q = cmd_q;
          end
        end
        CMD_QUERYADJ: begin
          if (is_acc) begin
            inv_flag_d = ~inv_flag_q;
            state_d    = ST_READY;
          end else if (state_q != ST_READY) begin
            q_d      = q_adj;
            reload   = 1'b1;
            reload_q = q_adj;
          end
        end
        CMD_QUERYREP: begin
          if (state_q == ST_ARBITRATE) begin
            slot_d = slot_dec;
            if (slot_dec == 15'd0) begin
              state_d     = ST_REPLY;
              rn16_d      = r;
              rpl_valid_d = 1'b1;
              rpl_type_d  = RPL_RN16;
              rpl_data_d  = r;
            end
          end else if (state_q == ST_REPLY) begin
            slot_d  = 15'h7FFF;
            state_d = ST_ARBITRATE;
          end else if (is_acc) begin
            inv_flag_d = ~inv_flag_q;
            state_d    = ST_READY;
          end
        end
        CMD_ACK: begin
          if (state_q == ST_REPLY || state_q == ST_ACKED) begin
            if (cmd_rn == rn16_q) begin
              state_d     = ST_ACKED;
              rpl_valid_d = 1'b1;
              rpl_type_d  = RPL_EPC;
              rpl_data_d  = EPC_WORD;
            end else begin
              state_d = ST_ARBITRATE;
            end
          end else if (state_q == ST_OPEN) begin
            if (cmd_rn == handle_q) begin
              rpl_valid_d = 1'b1;
              rpl_type_d  = RPL_EPC;
              rpl_data_d  = EPC_WORD;
            end else begin
              state_d = ST_ARBITRATE;
            end
          end
        end
        CMD_NAK: begin
          if (state_q != ST_READY) state_d = ST_ARBITRATE;
        end
        CMD_REQRN: begin
          if (state_q == ST_ACKED && cmd_rn == rn16_q) begin
            state_d     = ST_OPEN;
            handle_d    = r;
            rpl_valid_d = 1'b1;
            rpl_type_d  = RPL_HANDLE;
            rpl_data_d  = r;
          end else if (state_q == ST_OPEN && cmd_rn == handle_q) begin
            rpl_valid_d = 1'b1;
            rpl_type_d  = RPL_RN16;
            rpl_data_d  = r;
          end
        end
        default: begin
        end
      endcase

      // Slot reload shared by QUERY and QUERYADJ; slot 0 replies at once
      if (reload) begin
        slot_new = slot_mask(r, reload_q);
        slot_d   = slot_new;
        if (slot_new == 15'd0) begin
          state_d     = ST_REPLY;
          rn16_d      = r;
          rpl_valid_d = 1'b1;
          rpl_type_d  = RPL_RN16;
          rpl_data_d  = r;
        end else begin
          state_d = ST_ARBITRATE;
        end
      end
    end
  end

  // State, counters and reply registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_READY;
      inv_flag_q  <= 1'b0;
      rpl_valid_q <= 1'b0;
      rpl_type_q  <= RPL_RN16;
      rpl_data_q  <= 16'd0;
      q_q         <= 4'd0;
      slot_q      <= 15'd0;
      rn16_q      <= 16'd0;
      handle_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      inv_flag_q  <= inv_flag_d;
      rpl_valid_q <= rpl_valid_d;
      rpl_type_q  <= rpl_type_d;
      rpl_data_q  <= rpl_data_d;
      q_q         <= q_d;
      slot_q      <= slot_d;
      rn16_q      <= rn16_d;
      handle_q    <= handle_d;
    end
  end

  assign cmd_ready = ~rpl_valid_q;
  assign rpl_valid = rpl_valid_q;
  assign rpl_type  = rpl_type_q;
  assign rpl_data  = rpl_data_q;
  assign tag_state = state_q;
  assign inv_flag  = inv_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_rfid_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rfid_tag_ctrl
// Description : Self-checking bench for rfid_tag_ctrl: directed scenarios
//               plus randomized traffic against a behavioural tag model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rfid_tag_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] EPC  = 16'h3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_crc_ok, cmd_target;
  logic [2:0]  cmd_code, cmd_updn;
  logic [3:0]  cmd_q;
  logic [15:0] cmd_rn;
  logic        rpl_valid, rpl_ready;
  logic [1:0]  rpl_type;
  logic [15:0] rpl_data;
  logic [2:0]  tag_state;
  logic        inv_flag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rfid_tag_ctrl #(.LFSR_SEED(SEED), .EPC_WORD(EPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_crc_ok(cmd_crc_ok), .cmd_q(cmd_q), .cmd_target(cmd_target),
    .cmd_updn(cmd_updn), .cmd_rn(cmd_rn),
    .rpl_valid(rpl_valid), .rpl_ready(rpl_ready), .rpl_type(rpl_type),
    .rpl_data(rpl_data), .tag_state(tag_state), .inv_flag(inv_flag)
  );

  // ---------------- behavioural tag model ----------------
  // states: 0 ready, 1 arbitrate, 2 reply, 3 acked, 4 open
  int          m_st, m_q, m_slot;
  logic        m_inv, m_rv;
  logic [1:0]  m_rt;
  logic [15:0] m_rd, m_rn16, m_handle, m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  task automatic model_emit(input logic [1:0] t, input logic [15:0] d);
    m_rv = 1'b1; m_rt = t; m_rd = d;
  endtask

  task automatic model_cmd(input logic [15:0] r);
    bit acc, reload;
    acc = (m_st == 3) || (m_st == 4);
    reload = 0;
    if (!cmd_crc_ok) return;
    case (cmd_code)
      3'd0: begin
        m_q = int'(cmd_q);
        if (acc) m_inv = ~m_inv;
        if (cmd_target != m_inv) m_st = 0; else reload = 1;
      end
      3'd2: begin
        if (acc) begin m_inv = ~m_inv; m_st = 0; end
        else if (m_st != 0) begin
          if (cmd_updn == 3'b110) m_q = (m_q == 15) ? 15 : m_q + 1;
          else if (cmd_updn == 3'b011) m_q = (m_q == 0) ? 0 : m_q - 1;
          reload = 1;
        end
      end
      3'd1: begin
        if (m_st == 1) begin
          m_slot = m_slot - 1;
          if (m_slot == 0) begin m_st = 2; m_rn16 = r; model_emit(2'd0, r); end
        end else if (m_st == 2) begin m_slot = 32767; m_st = 1; end
        else if (acc) begin m_inv = ~m_inv; m_st = 0; end
      end
      3'd3: begin
        if (m_st == 2 || m_st == 3) begin
          if (cmd_rn == m_rn16) begin m_st = 3; model_emit(2'd1, EPC); end else m_st = 1;
        end else if (m_st == 4) begin
          if (cmd_rn == m_handle) model_emit(2'd1, EPC); else m_st = 1;
        end
      end
      3'd4: if (m_st != 0) m_st = 1;
      3'd5: begin
        if (m_st == 3 && cmd_rn == m_rn16) begin m_st = 4; m_handle = r; model_emit(2'd2, r); end
        else if (m_st == 4 && cmd_rn == m_handle) model_emit(2'd0, r);
      end
      default: ;
    endcase
    if (reload) begin
      m_slot = int'(r[14:0]) % (1 << m_q);
      if (m_slot == 0) begin m_st = 2; m_rn16 = r; model_emit(2'd0, r); end
      else m_st = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_q = 0; m_slot = 0; m_inv = 0; m_rv = 0; m_rt = 0; m_rd = 0;
      m_rn16 = 0; m_handle = 0; m_lfsr = SEED;
    end else begin
      if (m_rv) begin
        if (rpl_ready) m_rv = 1'b0;
      end else if (cmd_valid) begin
        model_cmd(m_lfsr);
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // ---------------- stimulus helpers (call at a falling edge) ----------------
  task automatic send(input logic [2:0] code, input logic crc, input logic [3:0] q,
                      input logic tgt, input logic [2:0] updn, input logic [15:0] rn);
    cmd_code = code; cmd_crc_ok = crc; cmd_q = q; cmd_target = tgt;
    cmd_updn = updn; cmd_rn = rn; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic take();
    rpl_ready = 1'b1;
    @(negedge clk);
    rpl_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_cmp++; if (tag_state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", tag_state); end
    n_cmp++; if (inv_flag !== 1'b0) begin n_err++; $display("FAIL rst_inv: got %0b want 0", inv_flag); end
    n_cmp++; if (rpl_valid !== 1'b0) begin n_err++; $display("FAIL rst_rpl_valid: got %0b want 0", rpl_valid); end
    n_cmp++; if (rpl_type !== 2'd0 || rpl_data !== 16'd0) begin n_err++; $display("FAIL rst_rpl: got %0d/%h want 0/0000", rpl_type, rpl_data); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready); end
  endtask

  task automatic test_first_query();
    logic [15:0] exp_r;
    exp_r = m_lfsr;
    send(3'd0, 1'b1, 4'd0, 1'b0, 3'd0, 16'd0);
    n_cmp++; if (tag_state !== 3'd2) begin n_err++; $display("FAIL q0_state: got %0d want 2", tag_state); end
    n_cmp++; if (rpl_valid !== 1'b1 || rpl_type !== 2'd0) begin n_err++; $display("FAIL q0_rpl: got v%0b t%0d want v1 t0", rpl_valid, rpl_type); end
    n_cmp++; if (rpl_data !== exp_r) begin n_err++; $display("FAIL q0_data: got %h want %h", rpl_data, exp_r); end
    for (int i = 0; i < 5; i++) begin
      cmd_code = 3'd4; cmd_crc_ok = 1'b1; cmd_valid = 1'b1;
      @(negedge clk);
      n_cmp++; if (rpl_valid !== 1'b1 || rpl_type !== 2'd0 || rpl_data !== exp_r) begin n_err++; $display("FAIL hold_rpl: got v%0b t%0d %h want v1 t0 %h", rpl_valid, rpl_type, rpl_data, exp_r); end
      n_cmp++; if (cmd_ready !== 1'b0 || tag_state !== 3'd2) begin n_err++; $display("FAIL hold_block: got rdy%0b st%0d want rdy0 st2", cmd_ready, tag_state); end
    end
    cmd_valid = 1'b0;
    take();
    n_cmp++; if (rpl_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL consume: got v%0b rdy%0b want v0 rdy1", rpl_valid, cmd_ready); end
  endtask

  task automatic test_slot_count();
    logic [15:0] exp_r;
    bit found;
    found = 0;
    for (int i = 0; i < 500; i++) begin
      if (m_lfsr[3:0] == 4'd3) begin found = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL slot_search: got none want sample with low nibble 3"); end
    send(3'd0, 1'b1, 4'd4, 1'b0, 3'd0, 16'd0);
    n_cmp++; if (tag_state !== 3'd1 || rpl_valid !== 1'b0) begin n_err++; $display("FAIL slot3_arb: got st%0d v%0b want st1 v0", tag_state, rpl_valid); end
    for (int k = 1; k <= 3; k++) begin
      exp_r = m_lfsr;
      send(3'd1, 1'b1, 4'd0, 1'b0, 3'd0, 16'd0);
      if (k < 3) begin
        n_cmp++; if (tag_state !== 3'd1 || rpl_valid !== 1'b0) begin n_err++; $display("FAIL rep%0d: got st%0d v%0b want st1 v0", k, tag_state, rpl_valid); end
      end else begin
        n_cmp++; if (tag_state !== 3'd2 || rpl_valid !== 1'b1 || rpl_type !== 2'd0 || rpl_data !== exp_r) begin n_err++; $display("FAIL rep3_reply: got st%0d v%0b t%0d %h want st2 v1 t0 %h", tag_state, rpl_valid, rpl_type, rpl_data, exp_r); end
      end
    end
    take();
  endtask

  task automatic test_ack();
    send(3'd3, 1'b1, 4'd0, 1'b0, 3'd0, m_rn16);
    n_cmp++; if (tag_state !== 3'd3 || rpl_valid !== 1'b1 || rpl_type !== 2'd1 || rpl_data !== EPC) begin n_err++; $display("FAIL ack_ok: got st%0d v%0b t%0d %h want st3 v1 t1 3000", tag_state, rpl_valid, rpl_type, rpl_data); end
    take();
    send(3'd3, 1'b1, 4'd0, 1'b0, 3'd0, m_rn16 ^ 16'h0001);
    n_cmp++; if (tag_state !== 3'd1 || rpl_valid !== 1'b0) begin n_err++; $display("FAIL ack_bad: got st%0d v%0b want st1 v0", tag_state, rpl_valid); end
    send(3'd0, 1'b1, 4'd0, 1'b0, 3'd0, 16'd0);
    take();
    send(3'd3, 1'b1, 4'd0, 1'b0, 3'd0, m_rn16);
    take();
    n_cmp++; if (tag_state !== 3'd3) begin n_err++; $display("FAIL reack: got st%0d want st3", tag_state); end
  endtask

  task automatic test_open();
    logic [15:0] exp_r, h;
    exp_r = m_lfsr;
    send(3'd5, 1'b1, 4'd0, 1'b0, 3'd0, m_rn16);
    n_cmp++; if (tag_state !== 3'd4 || rpl_valid !== 1'b1 || rpl_type !== 2'd2 || rpl_data !== exp_r) begin n_err++; $display("FAIL reqrn_handle: got st%0d v%0b t%0d %h want st4 v1 t2 %h", tag_state, rpl_valid, rpl_type, rpl_data, exp_r); end
    take();
    h = exp_r;
    exp_r = m_lfsr;
    send(3'd5, 1'b1, 4'd0, 1'b0, 3'd0, h);
    n_cmp++; if (tag_state !== 3'd4 || rpl_valid !== 1'b1 || rpl_type !== 2'd0 || rpl_data !== exp_r) begin n_err++; $display("FAIL reqrn_rn16: got st%0d v%0b t%0d %h want st4 v1 t0 %h", tag_state, rpl_valid, rpl_type, rpl_data, exp_r); end
    take();
    send(3'd1, 1'b1, 4'd0, 1'b0, 3'd0, 16'd0);
    n_cmp++; if (tag_state !== 3'd0 || inv_flag !== 1'b1 || rpl_valid !== 1'b0) begin n_err++; $display("FAIL open_rep: got st%0d inv%0b v%0b want st0 inv1 v0", tag_state, inv_flag, rpl_valid); end
  endtask

  task automatic test_qadj();
    logic [15:0] exp_r;
    logic [2:0]  exp_st;
    send(3'd0, 1'b1, 4'd15, 1'b1, 3'd0, 16'd0);
    if (rpl_valid) take();
    exp_r = m_lfsr;
    exp_st = (exp_r[14:0] == 15'd0) ? 3'd2 : 3'd1;
    send(3'd2, 1'b1, 4'd0, 1'b0, 3'b110, 16'd0);
    n_cmp++; if (tag_state !== exp_st) begin n_err++; $display("FAIL qadj_sat15: got st%0d want st%0d", tag_state, exp_st); end
    if (rpl_valid) take();
    send(3'd0, 1'b1, 4'd0, 1'b1, 3'd0, 16'd0);
    take();
    exp_r = m_lfsr;
    send(3'd2, 1'b1, 4'd0, 1'b0, 3'b011, 16'd0);
    n_cmp++; if (tag_state !== 3'd2 || rpl_valid !== 1'b1 || rpl_data !== exp_r) begin n_err++; $display("FAIL qadj_sat0: got st%0d v%0b %h want st2 v1 %h", tag_state, rpl_valid, rpl_data, exp_r); end
    take();
    send(3'd0, 1'b0, 4'd5, 1'b0, 3'd0, 16'd0);
    n_cmp++; if (tag_state !== 3'd2 || inv_flag !== 1'b1 || rpl_valid !== 1'b0) begin n_err++; $display("FAIL crc_bad: got st%0d inv%0b v%0b want st2 inv1 v0", tag_state, inv_flag, rpl_valid); end
    send(3'd7, 1'b1, 4'd0, 1'b0, 3'd0, 16'd0);
    send(3'd6, 1'b1, 4'd0, 1'b0, 3'd0, 16'd0);
    n_cmp++; if (tag_state !== 3'd2 || rpl_valid !== 1'b0) begin n_err++; $display("FAIL other_cmd: got st%0d v%0b want st2 v0", tag_state, rpl_valid); end
  endtask

  task automatic test_random();
    logic [2:0] codes [8];
    codes = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    for (int i = 0; i < 600; i++) begin
      n_cmp++; if (tag_state !== 3'(m_st) || inv_flag !== m_inv) begin n_err++; $display("FAIL rnd_state[%0d]: got st%0d inv%0b want st%0d inv%0b", i, tag_state, inv_flag, m_st, m_inv); end
      n_cmp++; if (rpl_valid !== m_rv || cmd_ready !== !m_rv) begin n_err++; $display("FAIL rnd_hs[%0d]: got v%0b rdy%0b want v%0b", i, rpl_valid, cmd_ready, m_rv); end
      if (m_rv) begin
        n_cmp++; if (rpl_type !== m_rt || rpl_data !== m_rd) begin n_err++; $display("FAIL rnd_rpl[%0d]: got t%0d %h want t%0d %h", i, rpl_type, rpl_data, m_rt, m_rd); end
      end
      cmd_valid  = ($urandom_range(0, 3) != 0);
      cmd_code   = codes[$urandom_range(0, 7)];
      cmd_crc_ok = ($urandom_range(0, 9) != 0);
      cmd_q      = 4'($urandom_range(0, 3));
      cmd_target = ($urandom_range(0, 3) == 0) ? 1'($urandom) : (m_inv ^ (m_st == 3 || m_st == 4));
      case ($urandom_range(0, 3))
        0: cmd_updn = 3'b110;
        1: cmd_updn = 3'b011;
        2: cmd_updn = 3'b000;
        default: cmd_updn = 3'b101;
      endcase
      case ($urandom_range(0, 2))
        0: cmd_rn = m_rn16;
        1: cmd_rn = m_handle;
        default: cmd_rn = 16'($urandom);
      endcase
      rpl_ready = 1'($urandom);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rpl_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    if (rpl_valid) take();
    send(3'd0, 1'b1, 4'd0, m_inv ^ (m_st == 3 || m_st == 4), 3'd0, 16'd0);
    n_cmp++; if (rpl_valid !== 1'b1) begin n_err++; $display("FAIL ar_setup: got v%0b want v1", rpl_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rpl_valid !== 1'b0 || tag_state !== 3'd0 || inv_flag !== 1'b0) begin n_err++; $display("FAIL ar_async: got v%0b st%0d inv%0b want v0 st0 inv0", rpl_valid, tag_state, inv_flag); end
    n_cmp++; if (rpl_data !== 16'd0 || rpl_type !== 2'd0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL ar_outs: got %h t%0d rdy%0b want 0000 t0 rdy1", rpl_data, rpl_type, cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = 3'd0; cmd_crc_ok = 1'b1; cmd_q = 4'd0;
    cmd_target = 1'b0; cmd_updn = 3'd0; cmd_rn = 16'd0; rpl_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_first_query();
    test_slot_count();
    test_ack();
    test_open();
    test_qadj();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
